// File: rtl/ball_bouncer_multi.sv
// rtl/ball_bouncer_multi.sv - multi-ball bouncer: per-frame ball update FSM and registered RGB renderer
module ball_bouncer_multi #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BALL_SIZE = 4,
    parameter int NUM_BALLS = 4,
    parameter int SPEED     = 2,
    parameter int GRID_ON   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vsync,
    input  logic                 display_on,
    input  logic [9:0]           hpos,
    input  logic [9:0]           vpos,
    input  logic                 pause,
    output logic [2:0]           rgb,
    output logic                 frame_tick,
    output logic [NUM_BALLS-1:0] collide
);

    localparam int IDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;

    // Bounce limits are the largest top-left coordinate that keeps the ball on screen.
    localparam logic signed [10:0] X_LIMIT  = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [10:0] Y_LIMIT  = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_BALLS - 1);
    localparam logic signed [3:0]  VEL_POS  = 4'(SPEED);
    localparam logic signed [3:0]  VEL_NEG  = 4'(-SPEED);
    localparam logic [10:0]        SIZE_11  = 11'(BALL_SIZE);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_UPDATE = 1'b1
    } state_t;

    // Balls start on a diagonal, fanning out in all four directions.
    function automatic logic [9:0] init_x(input int i);
        return 10'(64 + 64 * i);
    endfunction

    function automatic logic [9:0] init_y(input int i);
        return 10'(64 + 32 * i);
    endfunction

    function automatic logic signed [3:0] init_dx(input int i);
        return ((i % 2) == 0) ? VEL_POS : VEL_NEG;
    endfunction

    function automatic logic signed [3:0] init_dy(input int i);
        return (((i / 2) % 2) == 0) ? VEL_POS : VEL_NEG;
    endfunction

    state_t                r_state;
    state_t                w_state_next;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_vsync_q;
    logic                  r_frame_tick;
    logic [NUM_BALLS-1:0]  r_collide;
    logic [2:0]            r_rgb;

    logic [9:0]            r_x  [NUM_BALLS];
    logic [9:0]            r_y  [NUM_BALLS];
    logic signed [3:0]     r_dx [NUM_BALLS];
    logic signed [3:0]     r_dy [NUM_BALLS];

    logic                  w_tick;
    logic                  w_update;

    logic [9:0]            w_cur_x;
    logic [9:0]            w_cur_y;
    logic signed [3:0]     w_cur_dx;
    logic signed [3:0]     w_cur_dy;
    logic signed [10:0]    w_sum_x;
    logic signed [10:0]    w_sum_y;
    logic [9:0]            w_new_x;
    logic [9:0]            w_new_y;
    logic signed [3:0]     w_new_dx;
    logic signed [3:0]     w_new_dy;
    logic                  w_bounce_x;
    logic                  w_bounce_y;

    logic                  w_hit;
    logic [2:0]            w_ball_rgb;
    logic                  w_grid;
    logic [2:0]            w_pix_rgb;

    assign w_tick = vsync & ~r_vsync_q;

    // Delay vsync one clock for rising-edge detection and register the frame pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vsync_q    <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_vsync_q    <= vsync;
            r_frame_tick <= w_tick;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: start a sweep on an unpaused tick, finish after the last ball.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_tick && !pause) w_state_next = S_UPDATE;
            S_UPDATE: if (r_idx == LAST_IDX) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs: ball registers are written only while sweeping.
    always_comb begin
        w_update = 1'b0;
        case (r_state)
            S_UPDATE: w_update = 1'b1;
            default:  w_update = 1'b0;
        endcase
    end

    // Ball index walks 0..NUM_BALLS-1 during a sweep and parks at 0 otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= '0;
        end else if (w_update && (r_idx != LAST_IDX)) begin
            r_idx <= r_idx + 1'b1;
        end else begin
            r_idx <= '0;
        end
    end

    // Select the ball being updated this cycle.
    always_comb begin
        w_cur_x  = r_x[r_idx];
        w_cur_y  = r_y[r_idx];
        w_cur_dx = r_dx[r_idx];
        w_cur_dy = r_dy[r_idx];
        w_sum_x  = {1'b0, w_cur_x} + {{7{w_cur_dx[3]}}, w_cur_dx};
        w_sum_y  = {1'b0, w_cur_y} + {{7{w_cur_dy[3]}}, w_cur_dy};
    end

    // X axis: clamp to the edge and reverse when the step would leave the screen.
    always_comb begin
        w_new_x    = w_sum_x[9:0];
        w_new_dx   = w_cur_dx;
        w_bounce_x = 1'b0;
        if (w_sum_x < 0) begin
            w_new_x    = '0;
            w_new_dx   = -w_cur_dx;
            w_bounce_x = 1'b1;
        end else if (w_sum_x > X_LIMIT) begin
            w_new_x    = X_LIMIT[9:0];
            w_new_dx   = -w_cur_dx;
            w_bounce_x = 1'b1;
        end
    end

    // Y axis: same clamp-and-reverse rule against the vertical limit.
    always_comb begin
        w_new_y    = w_sum_y[9:0];
        w_new_dy   = w_cur_dy;
        w_bounce_y = 1'b0;
        if (w_sum_y < 0) begin
            w_new_y    = '0;
            w_new_dy   = -w_cur_dy;
            w_bounce_y = 1'b1;
        end else if (w_sum_y > Y_LIMIT) begin
            w_new_y    = Y_LIMIT[9:0];
            w_new_dy   = -w_cur_dy;
            w_bounce_y = 1'b1;
        end
    end

    // Ball state: initial layout on reset, one ball rewritten per sweep cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                r_x[i]  <= init_x(i);
                r_y[i]  <= init_y(i);
                r_dx[i] <= init_dx(i);
                r_dy[i] <= init_dy(i);
            end
        end else if (w_update) begin
            r_x[r_idx]  <= w_new_x;
            r_y[r_idx]  <= w_new_y;
            r_dx[r_idx] <= w_new_dx;
            r_dy[r_idx] <= w_new_dy;
        end
    end

    // Collision pulse: one cycle after the ball's update, a corner hit gives a single pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_collide <= '0;
        end else begin
            r_collide <= '0;
            if (w_update) begin
                r_collide[r_idx] <= w_bounce_x | w_bounce_y;
            end
        end
    end

    // Hit test: scan from the highest index down so the lowest-index ball wins overlaps.
    always_comb begin
        w_hit      = 1'b0;
        w_ball_rgb = 3'b000;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (({1'b0, hpos} >= {1'b0, r_x[i]}) &&
                ({1'b0, hpos} <  ({1'b0, r_x[i]} + SIZE_11)) &&
                ({1'b0, vpos} >= {1'b0, r_y[i]}) &&
                ({1'b0, vpos} <  ({1'b0, r_y[i]} + SIZE_11))) begin
                w_hit      = 1'b1;
                w_ball_rgb = 3'((i % 7) + 1);
            end
        end
    end

    // Pixel colour: blanking, then balls, then the optional 8x8 dot grid.
    always_comb begin
        w_grid = (GRID_ON != 0) && (hpos[2:0] == 3'd0) && (vpos[2:0] == 3'd0);
        if (!display_on) begin
            w_pix_rgb = 3'b000;
        end else if (w_hit) begin
            w_pix_rgb = w_ball_rgb;
        end else if (w_grid) begin
            w_pix_rgb = 3'b010;
        end else begin
            w_pix_rgb = 3'b000;
        end
    end

    // Register the pixel so rgb trails the beam coordinates by exactly one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rgb <= 3'b000;
        end else begin
            r_rgb <= w_pix_rgb;
        end
    end

    assign rgb        = r_rgb;
    assign frame_tick = r_frame_tick;
    assign collide    = r_collide;

endmodule

// File: tb/tb_ball_bouncer_multi.sv
// tb/tb_ball_bouncer_multi.sv - randomized bench for ball_bouncer_multi against a frame-level model
module tb_ball_bouncer_multi;

    localparam int NB  = 4;
    localparam int BS  = 4;
    localparam int SPD = 2;
    localparam int HA  = 640;
    localparam int VA  = 480;

    logic          clk = 1'b0;
    logic          reset;
    logic          vsync;
    logic          display_on;
    logic [9:0]    hpos;
    logic [9:0]    vpos;
    logic          pause;
    logic [2:0]    rgb;
    logic          frame_tick;
    logic [NB-1:0] collide;

    int n_tests = 0;
    int n_fail  = 0;

    int mx [NB];
    int my [NB];
    int mdx[NB];
    int mdy[NB];
    int mcol[NB];

    ball_bouncer_multi #(
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .BALL_SIZE(BS),
        .NUM_BALLS(NB),
        .SPEED    (SPD),
        .GRID_ON  (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .vsync     (vsync),
        .display_on(display_on),
        .hpos      (hpos),
        .vpos      (vpos),
        .pause     (pause),
        .rgb       (rgb),
        .frame_tick(frame_tick),
        .collide   (collide)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_tests++;
        if (got !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            mx[i]  = 64 + 64 * i;
            my[i]  = 64 + 32 * i;
            mdx[i] = (i % 2 == 0) ? SPD : -SPD;
            mdy[i] = ((i / 2) % 2 == 0) ? SPD : -SPD;
        end
    endtask

    task automatic step_axis(inout int p, inout int v, input int lim, output bit b);
        int n;
        n = p + v;
        b = 1'b0;
        if (n < 0) begin
            p = 0; v = -v; b = 1'b1;
        end else if (n > lim) begin
            p = lim; v = -v; b = 1'b1;
        end else begin
            p = n;
        end
    endtask

    task automatic model_frame();
        bit bx, by;
        for (int i = 0; i < NB; i++) begin
            step_axis(mx[i], mdx[i], HA - BS, bx);
            step_axis(my[i], mdy[i], VA - BS, by);
            mcol[i] = (bx || by) ? 1 : 0;
        end
    endtask

    function automatic int model_rgb(input int h, input int v, input bit d);
        if (!d) return 0;
        for (int i = 0; i < NB; i++) begin
            if (h >= mx[i] && h < mx[i] + BS && v >= my[i] && v < my[i] + BS)
                return (i % 7) + 1;
        end
        if ((h % 8) == 0 && (v % 8) == 0) return 2;
        return 0;
    endfunction

    task automatic probe(input string tag, input int h, input int v, input bit d);
        @(negedge clk);
        hpos       = 10'(h);
        vpos       = 10'(v);
        display_on = d;
        @(negedge clk);
        chk($sformatf("%s(%0d,%0d,%0d)", tag, h, v, d), 32'(rgb), model_rgb(h, v, d));
    endtask

    task automatic probe_all();
        int h, v;
        for (int i = 0; i < NB; i++) begin
            probe($sformatf("b%0d_tl", i), mx[i], my[i], 1'b1);
            probe($sformatf("b%0d_br", i), mx[i] + BS - 1, my[i] + BS - 1, 1'b1);
            probe($sformatf("b%0d_rx", i), mx[i] + BS, my[i], 1'b1);
            if (mx[i] > 0) probe($sformatf("b%0d_lx", i), mx[i] - 1, my[i] + 1, 1'b1);
            if (my[i] > 0) probe($sformatf("b%0d_ty", i), mx[i] + 1, my[i] - 1, 1'b1);
        end
        h = $urandom_range(0, HA - 1);
        v = $urandom_range(0, VA - 1);
        probe("rnd", h, v, ($urandom_range(0, 3) != 0));
        probe("grid", h & ~7, v & ~7, 1'b1);
    endtask

    task automatic do_frame(input bit p);
        int ft_cnt;
        int col_cnt[NB];
        ft_cnt = 0;
        for (int i = 0; i < NB; i++) col_cnt[i] = 0;
        @(negedge clk);
        pause = p;
        vsync = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 2) vsync = 1'b0;
            ft_cnt += int'(frame_tick);
            for (int i = 0; i < NB; i++) col_cnt[i] += int'(collide[i]);
        end
        if (!p) model_frame();
        else for (int i = 0; i < NB; i++) mcol[i] = 0;
        chk("frame_tick", 32'(ft_cnt), 1);
        for (int i = 0; i < NB; i++)
            chk($sformatf("collide%0d", i), 32'(col_cnt[i]), mcol[i]);
    endtask

    initial begin
        reset      = 1'b1;
        vsync      = 1'b0;
        display_on = 1'b1;
        hpos       = 10'd64;
        vpos       = 10'd64;
        pause      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_frame_tick", 32'(frame_tick), 0);
        chk("rst_collide", 32'(collide), 0);
        reset = 1'b0;
        model_reset();

        probe("init_ball0", 64, 64, 1'b1);
        chk("init_ball0_const", 32'(rgb), 1);
        probe("init_grid", 0, 0, 1'b1);
        chk("init_grid_const", 32'(rgb), 2);
        probe("init_blank", 0, 0, 1'b0);
        chk("init_blank_const", 32'(rgb), 0);
        chk("idle_collide", 32'(collide), 0);
        chk("idle_frame_tick", 32'(frame_tick), 0);

        for (int f = 0; f < 10; f++) begin
            do_frame(1'b1);
        end
        probe_all();

        for (int f = 0; f < 300; f++) begin
            do_frame(($urandom_range(0, 7) == 0));
            probe_all();
        end

        // Abort a sweep after ball1 has been written; everything must snap back.
        @(negedge clk);
        pause = 1'b0;
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vsync = 1'b0;
        model_reset();
        chk("midrst_collide", 32'(collide), 0);
        chk("midrst_frame_tick", 32'(frame_tick), 0);
        probe_all();
        for (int f = 0; f < 5; f++) begin
            do_frame(1'b0);
            probe_all();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
